// File: rtl/ram_access_sched.sv
// ram_access_sched: shares one single-port RAM between the DMA master and
// custom logic. Commands use a req/gnt handshake. The RAM command outputs are
// registered. Read data is routed back to its owner with a one-cycle rvalid.
// DMA has fixed priority over custom logic.
// Optional feature: define STARVE_GUARD_EN to add a starvation counter. When
// custom logic has waited STARVE_MAX cycles, it gets one forced grant.
`timescale 1ns/1ps
module ram_access_sched #(
    parameter int W_ADDR     = 12,
    parameter int W_DATA     = 128,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [W_ADDR-1:0] dma_addr,
    input  logic [W_DATA-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [W_DATA-1:0] dma_rdata,
    output logic              dma_rvalid,
    input  logic              cus_req,
    input  logic              cus_we,
    input  logic [W_ADDR-1:0] cus_addr,
    input  logic [W_DATA-1:0] cus_wdata,
    output logic              cus_gnt,
    output logic [W_DATA-1:0] cus_rdata,
    output logic              cus_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [W_ADDR-1:0] ram_addr,
    output logic [W_DATA-1:0] ram_wdata,
    input  logic [W_DATA-1:0] ram_rd_data,
    output logic              busy
);

    logic force_cus;
    logic dma_acc;
    logic cus_acc;

    // Registered RAM command, plus the owner of that command (1 = custom)
    logic              ram_en_q,    ram_en_d;
    logic              ram_we_q,    ram_we_d;
    logic              ram_own_q,   ram_own_d;
    logic [W_ADDR-1:0] ram_addr_q,  ram_addr_d;
    logic [W_DATA-1:0] ram_wdata_q, ram_wdata_d;

    // Read-return pipeline: one valid bit and one owner tag per RD_LAT stage
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0] rd_own_q, rd_own_d;

    // The starvation guard is the only thing that can override DMA priority
    assign dma_gnt = dma_req & ~force_cus;
    assign cus_gnt = cus_req & (~dma_req | force_cus);
    assign dma_acc = dma_req & dma_gnt;
    assign cus_acc = cus_req & cus_gnt;

`ifdef STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign force_cus = (starve_q == CNT_MAX) & cus_req;

    // Count cycles that custom logic waits, saturating at the limit
    always_comb begin
        starve_d = starve_q;
        if (~cus_req | cus_gnt) begin
            starve_d = '0;
        end else if (starve_q != CNT_MAX) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Starvation counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_cus = 1'b0;
`endif

    // Launch the accepted command next cycle; without an accept, the payload holds
    always_comb begin
        ram_en_d    = dma_acc | cus_acc;
        ram_we_d    = ram_we_q;
        ram_own_d   = ram_own_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (cus_acc) begin
            ram_we_d    = cus_we;
            ram_own_d   = 1'b1;
            ram_addr_d  = cus_addr;
            ram_wdata_d = cus_wdata;
        end else if (dma_acc) begin
            ram_we_d    = dma_we;
            ram_own_d   = 1'b0;
            ram_addr_d  = dma_addr;
            ram_wdata_d = dma_wdata;
        end
    end

    // Shift each issued read's owner tag along with the RAM read latency
    always_comb begin
        rd_vld_d    = rd_vld_q;
        rd_own_d    = rd_own_q;
        rd_vld_d[0] = ram_en_q & ~ram_we_q;
        rd_own_d[0] = ram_own_q;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_own_d[i] = rd_own_q[i-1];
        end
    end

    // Command and read-pipeline registers; reset drops any read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_own_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_vld_q    <= '0;
            rd_own_q    <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_own_q   <= ram_own_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_vld_q    <= rd_vld_d;
            rd_own_q    <= rd_own_d;
        end
    end

    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

    assign dma_rvalid = rd_vld_q[RD_LAT-1] & ~rd_own_q[RD_LAT-1];
    assign cus_rvalid = rd_vld_q[RD_LAT-1] &  rd_own_q[RD_LAT-1];
    assign dma_rdata  = dma_rvalid ? ram_rd_data : '0;
    assign cus_rdata  = cus_rvalid ? ram_rd_data : '0;
    assign busy       = |rd_vld_q;

endmodule
